// File: rtl/sym_err_counter.sv
// Self-aligning symbol-error counter behind the 4-ASK slicer: searches the tx->rx
// delay tap, then counts symbols and errors over hold-bounded windows.
module sym_err_counter #(
  parameter int unsigned MAX_DELAY   = 8,
  parameter int unsigned SEARCH_LEN  = 64,
  parameter int unsigned LOCK_THRESH = 2,
  parameter int unsigned COUNT_W     = 22
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clk_en,
  input  logic [1:0]                   sym_tx,
  input  logic [1:0]                   sym_rx,
  input  logic                         hold,
  output logic [$clog2(MAX_DELAY)-1:0] delay_sel,
  output logic                         locked,
  output logic [COUNT_W-1:0]           sym_count,
  output logic [COUNT_W-1:0]           err_count,
  output logic                         result_valid
);

  localparam int unsigned DW = $clog2(MAX_DELAY);
  localparam int unsigned WW = $clog2(SEARCH_LEN) + 1;
  localparam logic [COUNT_W-1:0] CntMax = '1;

  typedef enum logic {StSearch, StLocked} state_e;

  state_e              state_q, state_d;
  logic [1:0]          dly_q [MAX_DELAY-1];
  logic [1:0]          taps  [MAX_DELAY];
  logic [DW-1:0]       delay_sel_q, delay_sel_d, next_sel;
  logic [WW-1:0]       win_cnt_q, win_cnt_d;
  logic [WW-1:0]       search_err_q, search_err_d, search_total;
  logic [COUNT_W-1:0]  sym_acc_q, sym_acc_d, err_acc_q, err_acc_d;
  logic [COUNT_W-1:0]  sym_count_q, sym_count_d, err_count_q, err_count_d;
  logic [COUNT_W-1:0]  sym_sat, err_sat;
  logic                valid_q, valid_d;
  logic                mismatch, win_end, search_pass, lose_lock;

  // Tap 0 is the live transmit symbol; tap k is sym_tx delayed by k enables.
  always_comb begin
    taps[0] = sym_tx;
    for (int k = 1; k < int'(MAX_DELAY); k++) begin
      taps[k] = dly_q[k-1];
    end
  end

  always_comb begin
    mismatch     = (sym_rx != taps[delay_sel_q]);
    next_sel     = (delay_sel_q == DW'(MAX_DELAY - 1)) ? '0 : delay_sel_q + 1'b1;
    win_end      = (win_cnt_q == WW'(SEARCH_LEN - 1));
    search_total = search_err_q + WW'(mismatch);
    search_pass  = (search_total <= WW'(LOCK_THRESH));
    sym_sat      = (sym_acc_q == CntMax) ? CntMax : sym_acc_q + 1'b1;
    err_sat      = (err_acc_q == CntMax) ? CntMax : err_acc_q + COUNT_W'(mismatch);
    // Window is unusable once errors exceed a quarter of the symbols.
    lose_lock    = (err_sat > (sym_sat >> 2));
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StSearch;
      delay_sel_q  <= '0;
      win_cnt_q    <= '0;
      search_err_q <= '0;
      sym_acc_q    <= '0;
      err_acc_q    <= '0;
      sym_count_q  <= '0;
      err_count_q  <= '0;
      valid_q      <= 1'b0;
      for (int k = 0; k < int'(MAX_DELAY) - 1; k++) begin
        dly_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      delay_sel_q  <= delay_sel_d;
      win_cnt_q    <= win_cnt_d;
      search_err_q <= search_err_d;
      sym_acc_q    <= sym_acc_d;
      err_acc_q    <= err_acc_d;
      sym_count_q  <= sym_count_d;
      err_count_q  <= err_count_d;
      valid_q      <= valid_d;
      if (clk_en) begin
        dly_q[0] <= sym_tx;
        for (int k = 1; k < int'(MAX_DELAY) - 1; k++) begin
          dly_q[k] <= dly_q[k-1];
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clk_en) begin
      unique case (state_q)
        StSearch: if (win_end && search_pass) state_d = StLocked;
        StLocked: if (hold && lose_lock) state_d = StSearch;
        default:  state_d = StSearch;
      endcase
    end
  end

  // Datapath next values
  always_comb begin
    delay_sel_d  = delay_sel_q;
    win_cnt_d    = win_cnt_q;
    search_err_d = search_err_q;
    sym_acc_d    = sym_acc_q;
    err_acc_d    = err_acc_q;
    sym_count_d  = sym_count_q;
    err_count_d  = err_count_q;
    valid_d      = 1'b0;
    if (clk_en) begin
      unique case (state_q)
        StSearch: begin
          win_cnt_d    = win_cnt_q + 1'b1;
          search_err_d = search_total;
          sym_acc_d    = '0;
          err_acc_d    = '0;
          if (win_end) begin
            win_cnt_d    = '0;
            search_err_d = '0;
            if (!search_pass) delay_sel_d = next_sel;
          end
        end
        StLocked: begin
          sym_acc_d = sym_sat;
          err_acc_d = err_sat;
          if (hold) begin
            sym_count_d = sym_sat;
            err_count_d = err_sat;
            sym_acc_d   = '0;
            err_acc_d   = '0;
            valid_d     = 1'b1;
            if (lose_lock) begin
              delay_sel_d  = next_sel;
              win_cnt_d    = '0;
              search_err_d = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    locked       = (state_q == StLocked);
    delay_sel    = delay_sel_q;
    sym_count    = sym_count_q;
    err_count    = err_count_q;
    result_valid = valid_q;
  end

endmodule

// File: tb/tb_sym_err_counter.sv
// Directed bench for sym_err_counter: a default instance and a COUNT_W=8 instance
// share one stimulus stream built from a random symbol history and a channel delay.
module tb_sym_err_counter;

  logic        clk = 1'b0;
  logic        reset, clk_en, hold;
  logic [1:0]  sym_tx, sym_rx;

  logic [2:0]  d_sel, d8_sel;
  logic        d_lock, d8_lock, d_valid, d8_valid;
  logic [21:0] d_sym, d_err;
  logic [7:0]  d8_sym, d8_err;

  logic [1:0]  hist [8192];
  int          n = 0;
  int          chan = 3;
  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_err;

  always #5 clk = ~clk;

  sym_err_counter dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .sym_tx(sym_tx), .sym_rx(sym_rx),
    .hold(hold), .delay_sel(d_sel), .locked(d_lock), .sym_count(d_sym),
    .err_count(d_err), .result_valid(d_valid)
  );

  sym_err_counter #(.COUNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .sym_tx(sym_tx), .sym_rx(sym_rx),
    .hold(hold), .delay_sel(d8_sel), .locked(d8_lock), .sym_count(d8_sym),
    .err_count(d8_err), .result_valid(d8_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Disabled cycle with hold high and a corrupted rx: must have no effect.
  task automatic idle();
    clk_en = 1'b0;
    hold   = 1'b1;
    sym_rx = ~sym_rx;
    @(posedge clk);
    #1;
    hold = 1'b0;
  endtask

  task automatic step(input logic h, input logic flip);
    idle();
    sym_tx = hist[n];
    sym_rx = ((n >= chan) ? hist[n-chan] : 2'b00) ^ {1'b0, flip};
    hold   = h;
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    clk_en = 1'b0;
    hold   = 1'b0;
    n++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8192; i++) hist[i] = 2'($urandom_range(0, 3));
    reset = 1'b1; clk_en = 1'b0; hold = 1'b0; sym_tx = '0; sym_rx = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_delay_sel", 32'(d_sel), 0);
    chk("rst_locked", 32'(d_lock), 0);
    chk("rst_sym_count", 32'(d_sym), 0);
    chk("rst_err_count", 32'(d_err), 0);
    chk("rst_valid", 32'(d_valid), 0);
    reset = 1'b0;

    // Search with channel delay 3: taps 0..2 fail, lock on enable 256.
    repeat (64) step(1'b0, 1'b0);
    chk("search_tap1_sel", 32'(d_sel), 1);
    chk("search_tap1_lock", 32'(d_lock), 0);
    repeat (191) step(1'b0, 1'b0);
    chk("pre_lock_sel", 32'(d_sel), 3);
    chk("pre_lock_lock", 32'(d_lock), 0);
    step(1'b0, 1'b0);
    chk("lock_rise", 32'(d_lock), 1);
    chk("lock_sel", 32'(d_sel), 3);
    chk("lock8_rise", 32'(d8_lock), 1);

    // Error-free 1000-symbol window.
    repeat (999) step(1'b0, 1'b0);
    chk("valid_before_hold", 32'(d_valid), 0);
    step(1'b1, 1'b0);
    chk("win_valid", 32'(d_valid), 1);
    chk("win_sym", 32'(d_sym), 1000);
    chk("win_err", 32'(d_err), 0);
    chk("win8_sym_sat", 32'(d8_sym), 255);
    idle();
    chk("valid_pulse_end", 32'(d_valid), 0);

    // Ten forced flips in a 1000-symbol window.
    for (int i = 1; i <= 1000; i++) step(i == 1000, (i % 100) == 50);
    chk("flip_sym", 32'(d_sym), 1000);
    chk("flip_err", 32'(d_err), 10);
    chk("flip_lock", 32'(d_lock), 1);
    chk("flip8_err", 32'(d8_err), 10);
    chk("flip8_lock", 32'(d8_lock), 1);

    // Hold on the enable right after a hold: one-symbol window.
    step(1'b1, 1'b0);
    chk("back2back_sym", 32'(d_sym), 1);
    chk("back2back_err", 32'(d_err), 0);

    // Channel delay jumps to 5 while locked at tap 3.
    chan = 5;
    exp_err = 0;
    for (int i = 1; i <= 1000; i++) begin
      if (hist[n-5] != hist[n-3]) exp_err++;
      step(i == 1000, 1'b0);
    end
    chk("slip_sym", 32'(d_sym), 1000);
    chk("slip_err", 32'(d_err), 32'(exp_err));
    chk("slip_lock", 32'(d_lock), 0);
    chk("slip_sel", 32'(d_sel), 4);
    chk("slip8_err_sat", 32'(d8_err), 255);
    chk("slip8_lock", 32'(d8_lock), 0);

    // Relock at tap 5 after 128 enables.
    repeat (127) step(1'b0, 1'b0);
    chk("relock_pre_lock", 32'(d_lock), 0);
    chk("relock_pre_sel", 32'(d_sel), 5);
    step(1'b0, 1'b0);
    chk("relock_lock", 32'(d_lock), 1);
    chk("relock_sel", 32'(d_sel), 5);

    // Hold on the very first locked enable.
    step(1'b1, 1'b0);
    chk("first_hold_sym", 32'(d_sym), 1);
    chk("first_hold_err", 32'(d_err), 0);
    chk("first_hold_valid", 32'(d_valid), 1);

    // 300-symbol window: saturates only the narrow instance.
    repeat (299) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("w300_sym", 32'(d_sym), 300);
    chk("w300_sym8_sat", 32'(d8_sym), 255);
    chk("w300_err8", 32'(d8_err), 0);

    // Asynchronous reset between clock edges.
    #2;
    reset = 1'b1;
    #1;
    chk("async_sel", 32'(d_sel), 0);
    chk("async_lock", 32'(d_lock), 0);
    chk("async_sym", 32'(d_sym), 0);
    chk("async_err", 32'(d_err), 0);
    chk("async_valid", 32'(d_valid), 0);
    chk("async8_sym", 32'(d8_sym), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Channel delay 9 is out of reach: never locks, delay_sel wraps every 512.
    chan = 9;
    for (int i = 1; i <= 512; i++) begin
      step(1'b0, 1'b0);
      chk("far_lock", 32'(d_lock), 0);
      if ((i % 64) == 0) chk("far_sel", 32'(d_sel), 32'((i / 64) % 8));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
